// File: rtl/rgb2ycbcr_container.sv
`default_nettype none
// ============================================================================
// Module      : rgb2ycbcr_container
// Description : Converts one 8x8 tile (pixel_count pixels) of unsigned RGB
//               samples into full-range JPEG YCbCr (BT.601) in parallel.
//               Results are Q16.16 fixed point, registered once, so the
//               latency is exactly one clock.
//               Optional macro RGB2YCBCR_CLAMP_EN: when defined, each result
//               saturates to [0, 255.0] before it is registered.
// Ports       : clk     - rising-edge clock
//               rst     - asynchronous active-high reset, clears all outputs
//               r_all   - R samples, pixel i = [i*input_width +: input_width]
//               g_all   - G samples, same packing
//               b_all   - B samples, same packing
//               y_all   - Y,  pixel i = [i*fixed_point_length +: fixed_point_length]
//               cb_all  - Cb, same packing
//               cr_all  - Cr, same packing
// Revision    : 1.0 - initial release
// ============================================================================
module rgb2ycbcr_container #(
    parameter int fixed_point_length = 32,
    parameter int input_width        = 8,
    parameter int pixel_count        = 64
) (
    input  logic                                       clk,
    input  logic                                       rst,
    input  logic [input_width*pixel_count-1:0]         r_all,
    input  logic [input_width*pixel_count-1:0]         g_all,
    input  logic [input_width*pixel_count-1:0]         b_all,
    output logic [fixed_point_length*pixel_count-1:0]  y_all,
    output logic [fixed_point_length*pixel_count-1:0]  cb_all,
    output logic [fixed_point_length*pixel_count-1:0]  cr_all
);

    // Coefficients are < 2^16, so a product needs input_width+16 bits; three
    // terms plus the 128.0 offset add two bits and the sign adds one more.
    localparam int c_ACC_W = input_width + 19;
    localparam int c_OUT_W = fixed_point_length * pixel_count;

    // Q16.16 coefficients; each row sums to 65536 (Y) or 0 (Cb, Cr), which
    // makes grey inputs convert exactly.
    localparam logic signed [c_ACC_W-1:0] c_Y_R    = c_ACC_W'(19595);
    localparam logic signed [c_ACC_W-1:0] c_Y_G    = c_ACC_W'(38470);
    localparam logic signed [c_ACC_W-1:0] c_Y_B    = c_ACC_W'(7471);
    localparam logic signed [c_ACC_W-1:0] c_CB_R   = c_ACC_W'(11058);
    localparam logic signed [c_ACC_W-1:0] c_CB_G   = c_ACC_W'(21710);
    localparam logic signed [c_ACC_W-1:0] c_CB_B   = c_ACC_W'(32768);
    localparam logic signed [c_ACC_W-1:0] c_CR_R   = c_ACC_W'(32768);
    localparam logic signed [c_ACC_W-1:0] c_CR_G   = c_ACC_W'(27439);
    localparam logic signed [c_ACC_W-1:0] c_CR_B   = c_ACC_W'(5329);
    localparam logic signed [c_ACC_W-1:0] c_OFFSET = c_ACC_W'(32'h0080_0000);
`ifdef RGB2YCBCR_CLAMP_EN
    localparam logic signed [c_ACC_W-1:0] c_SAT    = c_ACC_W'(32'h00FF_0000);
`endif

    // Converts a lane result to the output word: optional saturation, then
    // zero extension (results are never negative in the raw build).
    function automatic logic [fixed_point_length-1:0] to_fixed(
        input logic signed [c_ACC_W-1:0] v
    );
        logic signed [c_ACC_W-1:0] s;
        s = v;
`ifdef RGB2YCBCR_CLAMP_EN
        if (v[c_ACC_W-1]) begin
            s = '0;
        end else if (v > c_SAT) begin
            s = c_SAT;
        end
`endif
        return fixed_point_length'($unsigned(s));
    endfunction

    logic [c_OUT_W-1:0] w_y_all;
    logic [c_OUT_W-1:0] w_cb_all;
    logic [c_OUT_W-1:0] w_cr_all;
    logic [c_OUT_W-1:0] r_y_all;
    logic [c_OUT_W-1:0] r_cb_all;
    logic [c_OUT_W-1:0] r_cr_all;

    // One identical converter lane per pixel; lanes never interact.
    for (genvar i = 0; i < pixel_count; i++) begin : g_lane
        logic signed [c_ACC_W-1:0] w_r;
        logic signed [c_ACC_W-1:0] w_g;
        logic signed [c_ACC_W-1:0] w_b;
        logic signed [c_ACC_W-1:0] w_y;
        logic signed [c_ACC_W-1:0] w_cb;
        logic signed [c_ACC_W-1:0] w_cr;

        // Zero-extend the unsigned samples into the signed datapath.
        assign w_r = c_ACC_W'(r_all[i*input_width +: input_width]);
        assign w_g = c_ACC_W'(g_all[i*input_width +: input_width]);
        assign w_b = c_ACC_W'(b_all[i*input_width +: input_width]);

        assign w_y  = c_Y_R * w_r + c_Y_G * w_g + c_Y_B * w_b;
        assign w_cb = c_OFFSET - c_CB_R * w_r - c_CB_G * w_g + c_CB_B * w_b;
        assign w_cr = c_OFFSET + c_CR_R * w_r - c_CR_G * w_g - c_CR_B * w_b;

        assign w_y_all [i*fixed_point_length +: fixed_point_length] = to_fixed(w_y);
        assign w_cb_all[i*fixed_point_length +: fixed_point_length] = to_fixed(w_cb);
        assign w_cr_all[i*fixed_point_length +: fixed_point_length] = to_fixed(w_cr);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_y_all  <= '0;
            r_cb_all <= '0;
            r_cr_all <= '0;
        end else begin
            r_y_all  <= w_y_all;
            r_cb_all <= w_cb_all;
            r_cr_all <= w_cr_all;
        end
    end

    assign y_all  = r_y_all;
    assign cb_all = r_cb_all;
    assign cr_all = r_cr_all;

endmodule
`default_nettype wire

// File: tb/tb_rgb2ycbcr_container.sv
`default_nettype none
// ============================================================================
// Module      : tb_rgb2ycbcr_container
// Description : Self-checking bench for rgb2ycbcr_container. A driver applies
//               directed and random tiles and queues the expected tile; a
//               monitor pops and compares one cycle later, then confirms the
//               outputs hold until the next clock edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rgb2ycbcr_container;

    localparam int c_IW = 8;
    localparam int c_FW = 32;
    localparam int c_PC = 64;
    localparam int c_INW  = c_IW * c_PC;
    localparam int c_OUTW = c_FW * c_PC;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [c_INW-1:0]  r_all = '0;
    logic [c_INW-1:0]  g_all = '0;
    logic [c_INW-1:0]  b_all = '0;
    logic [c_OUTW-1:0] y_all;
    logic [c_OUTW-1:0] cb_all;
    logic [c_OUTW-1:0] cr_all;

    logic [c_OUTW-1:0] q_y[$];
    logic [c_OUTW-1:0] q_cb[$];
    logic [c_OUTW-1:0] q_cr[$];

    logic drv_valid = 1'b0;
    logic mon_pend  = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;

    rgb2ycbcr_container #(
        .fixed_point_length (c_FW),
        .input_width        (c_IW),
        .pixel_count        (c_PC)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .r_all  (r_all),
        .g_all  (g_all),
        .b_all  (b_all),
        .y_all  (y_all),
        .cb_all (cb_all),
        .cr_all (cr_all)
    );

    always #5 clk = ~clk;

    // A tile driven before a rising edge is due at the following falling edge.
    always @(posedge clk) mon_pend <= drv_valid;

    // Reference: the BT.601 full-range formulas in Q16.16, per pixel.
    function automatic logic [31:0] model(input int ch, input int r, input int g, input int b);
        longint v;
        case (ch)
            0:       v = 19595 * r + 38470 * g + 7471 * b;
            1:       v = 128 * 65536 - 11058 * r - 21710 * g + 32768 * b;
            default: v = 128 * 65536 + 32768 * r - 27439 * g - 5329 * b;
        endcase
`ifdef RGB2YCBCR_CLAMP_EN
        if (v < 0) v = 0;
        if (v > 255 * 65536) v = 255 * 65536;
`endif
        return v[31:0];
    endfunction

    task automatic apply_now(input logic [c_INW-1:0] rr, input logic [c_INW-1:0] gg,
                             input logic [c_INW-1:0] bb);
        logic [c_OUTW-1:0] ey, ecb, ecr;
        for (int i = 0; i < c_PC; i++) begin
            int r, g, b;
            r = int'(rr[i*c_IW +: c_IW]);
            g = int'(gg[i*c_IW +: c_IW]);
            b = int'(bb[i*c_IW +: c_IW]);
            ey [i*c_FW +: c_FW] = model(0, r, g, b);
            ecb[i*c_FW +: c_FW] = model(1, r, g, b);
            ecr[i*c_FW +: c_FW] = model(2, r, g, b);
        end
        r_all = rr;
        g_all = gg;
        b_all = bb;
        q_y.push_back(ey);
        q_cb.push_back(ecb);
        q_cr.push_back(ecr);
        drv_valid = 1'b1;
    endtask

    task automatic apply_block(input logic [c_INW-1:0] rr, input logic [c_INW-1:0] gg,
                               input logic [c_INW-1:0] bb);
        @(negedge clk);
        apply_now(rr, gg, bb);
    endtask

    task automatic check_zero(input string name);
        n_vec++;
        if (y_all != '0 || cb_all != '0 || cr_all != '0) begin
            n_err++;
            $display("FAIL %s: outputs not zero (y[31:0]=%h cb[31:0]=%h cr[31:0]=%h), required 0",
                     name, y_all[31:0], cb_all[31:0], cr_all[31:0]);
        end
    endtask

    // Monitor: compare every due tile against the scoreboard, then verify the
    // outputs hold while the inputs change before the next edge.
    initial begin
        logic [c_OUTW-1:0] ey, ecb, ecr, sy, scb, scr;
        forever begin
            @(negedge clk);
            if (mon_pend) begin
                n_vec++;
                if (q_y.size() == 0) begin
                    n_err++;
                    $display("FAIL scoreboard: output due but queue empty, got 0 entries, required 1");
                end else begin
                    bit bad;
                    ey  = q_y.pop_front();
                    ecb = q_cb.pop_front();
                    ecr = q_cr.pop_front();
                    bad = 1'b0;
                    for (int i = 0; i < c_PC; i++) begin
                        for (int ch = 0; ch < 3; ch++) begin
                            logic [31:0] a, e;
                            a = (ch == 0) ? y_all[i*c_FW +: c_FW] :
                                (ch == 1) ? cb_all[i*c_FW +: c_FW] : cr_all[i*c_FW +: c_FW];
                            e = (ch == 0) ? ey[i*c_FW +: c_FW] :
                                (ch == 1) ? ecb[i*c_FW +: c_FW] : ecr[i*c_FW +: c_FW];
                            if (a != e && !bad) begin
                                bad = 1'b1;
                                $display("FAIL convert: pixel %0d chan %0d got %h required %h",
                                         i, ch, a, e);
                            end
                        end
                    end
                    if (bad) n_err++;
                end
                sy  = y_all;
                scb = cb_all;
                scr = cr_all;
                #4;
                n_vec++;
                if (y_all != sy || cb_all != scb || cr_all != scr) begin
                    n_err++;
                    $display("FAIL hold: outputs changed before clock edge, got y[31:0]=%h required %h",
                             y_all[31:0], sy[31:0]);
                end
            end
        end
    end

    // Driver
    initial begin
        logic [c_INW-1:0] rr, gg, bb;

        // Reset held with random inputs: outputs must stay cleared.
        for (int k = 0; k < c_INW / 32; k++) begin
            r_all[k*32 +: 32] = $urandom;
            g_all[k*32 +: 32] = $urandom;
            b_all[k*32 +: 32] = $urandom;
        end
        repeat (3) @(negedge clk);
        check_zero("reset_hold");

        // First edge after release loads the tile present at that edge.
        rst = 1'b0;
        apply_now('0, '0, '0);

        rr = '1;
        apply_block(rr, rr, rr);

        rr = '0;
        rr[7:0] = 8'hFF;
        apply_block(rr, '0, '0);

        bb = '0;
        bb[c_INW-1 -: 8] = 8'hFF;
        apply_block('0, '0, bb);

        for (int i = 0; i < c_PC; i++) rr[i*c_IW +: c_IW] = 8'($urandom_range(0, 255));
        apply_block(rr, rr, rr);

        for (int n = 0; n < 100; n++) begin
            for (int k = 0; k < c_INW / 32; k++) begin
                rr[k*32 +: 32] = $urandom;
                gg[k*32 +: 32] = $urandom;
                bb[k*32 +: 32] = $urandom;
            end
            apply_block(rr, gg, bb);
        end

        @(negedge clk);
        drv_valid = 1'b0;
        repeat (3) @(negedge clk);
        n_vec++;
        if (q_y.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d tiles never checked, required 0", q_y.size());
        end

        // Mid-stream reset clears outputs without waiting for a clock edge.
        #2 rst = 1'b1;
        #1 check_zero("async_reset");
        for (int k = 0; k < c_INW / 32; k++) begin
            r_all[k*32 +: 32] = $urandom;
            g_all[k*32 +: 32] = $urandom;
            b_all[k*32 +: 32] = $urandom;
        end
        @(negedge clk);
        check_zero("reset_held");

        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < c_INW / 32; k++) begin
            rr[k*32 +: 32] = $urandom;
            gg[k*32 +: 32] = $urandom;
            bb[k*32 +: 32] = $urandom;
        end
        apply_now(rr, gg, bb);
        @(negedge clk);
        drv_valid = 1'b0;
        repeat (3) @(negedge clk);
        n_vec++;
        if (q_y.size() != 0) begin
            n_err++;
            $display("FAIL drain_after_reset: %0d tiles never checked, required 0", q_y.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
